// File: rtl/alu_pkg.sv
// alu_pkg: shared constants, flag layout and FSM state type for alu_seq.
// Statistics are built only when ALU_SEQ_STATS_EN is defined.
package alu_pkg;

  // Default datapath widths
  localparam int unsigned DATA_W_DEF = 10;
  localparam int unsigned OPC_W_DEF  = 3;
  localparam int unsigned FLAG_W     = 4;

  // Statistics counter widths
  localparam int unsigned OP_CNT_W  = 16;
  localparam int unsigned OVF_CNT_W = 8;

  // Bit positions inside the 4-bit flag vector {NEG,POS,ZERO,OVF}
  localparam int unsigned FLAG_NEG  = 3;
  localparam int unsigned FLAG_POS  = 2;
  localparam int unsigned FLAG_ZERO = 1;
  localparam int unsigned FLAG_OVF  = 0;

  // Opcodes
  localparam logic [2:0] OPC_ADD  = 3'd0;
  localparam logic [2:0] OPC_SUB  = 3'd1;
  localparam logic [2:0] OPC_MAX  = 3'd2;
  localparam logic [2:0] OPC_MIN  = 3'd3;
  localparam logic [2:0] OPC_AND  = 3'd4;
  localparam logic [2:0] OPC_ORR  = 3'd5;
  localparam logic [2:0] OPC_XOR  = 3'd6;
  localparam logic [2:0] OPC_XNOR = 3'd7;

  // Flag payload as seen on the ALU and response busses
  typedef struct packed {
    logic neg;
    logic pos;
    logic zero;
    logic ovf;
  } alu_flag_t;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } alu_state_e;

  // True when a flag vector reports signed overflow
  function automatic logic flag_is_ovf(input alu_flag_t f);
    return f.ovf;
  endfunction

endpackage

// File: rtl/alu_seq_stats.sv
// alu_seq_stats: response and overflow counters for alu_seq.
// Only present in builds with ALU_SEQ_STATS_EN defined.
`ifdef ALU_SEQ_STATS_EN
module alu_seq_stats
  import alu_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rsp_hs,
  input  logic                 i_ovf_evt,
  output logic [OP_CNT_W-1:0]  o_op_count,
  output logic [OVF_CNT_W-1:0] o_ovf_count
);

  logic [OP_CNT_W-1:0]  op_cnt_q, op_cnt_d;
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  // Response count wraps; overflow count saturates at all-ones
  always_comb begin
    op_cnt_d  = op_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (i_rsp_hs) begin
      op_cnt_d = op_cnt_q + OP_CNT_W'(1);
    end
    if (i_ovf_evt && (ovf_cnt_q != {OVF_CNT_W{1'b1}})) begin
      ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
    end
  end

  // Counter registers with synchronous clear
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      op_cnt_q  <= '0;
      ovf_cnt_q <= '0;
    end else begin
      op_cnt_q  <= op_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign o_op_count  = op_cnt_q;
  assign o_ovf_count = ovf_cnt_q;

endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq: one-command-at-a-time sequencer around an external combinational ALU,
// with an accumulator for chained operations. Statistics via ALU_SEQ_STATS_EN.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OPC_W  = OPC_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [DATA_W-1:0]    i_cmd_arg0,
  input  logic [DATA_W-1:0]    i_cmd_arg1,
  input  logic [OPC_W-1:0]     i_cmd_oper,
  input  logic                 i_cmd_chain,
  output logic [DATA_W-1:0]    o_alu_arg0,
  output logic [DATA_W-1:0]    o_alu_arg1,
  output logic [OPC_W-1:0]     o_alu_oper,
  input  logic [DATA_W-1:0]    i_alu_result,
  input  logic [FLAG_W-1:0]    i_alu_flag,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [DATA_W-1:0]    o_rsp_result,
  output logic [FLAG_W-1:0]    o_rsp_flag,
  output logic [OP_CNT_W-1:0]  o_op_count,
  output logic [OVF_CNT_W-1:0] o_ovf_count
);

  alu_state_e state_q, state_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] alu_arg0_q, alu_arg0_d;
  logic [DATA_W-1:0] alu_arg1_q, alu_arg1_d;
  logic [OPC_W-1:0]  alu_oper_q, alu_oper_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  alu_flag_t         rsp_flag_q, rsp_flag_d;

  logic cmd_hs_c;
  logic rsp_hs_c;
  logic capture_c;

  // Handshake and capture strobes decoded from the current state
  assign cmd_hs_c  = i_cmd_valid && (state_q == ST_IDLE);
  assign rsp_hs_c  = i_rsp_ready && (state_q == ST_RESP);
  assign capture_c = (state_q == ST_ISSUE);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> ISSUE (one cycle) -> RESP until consumed
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_hs_c) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  if (rsp_hs_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; everything holds unless loaded or captured
  always_comb begin
    cmd_ready_d  = (state_d == ST_IDLE);
    rsp_valid_d  = (state_d == ST_RESP);
    acc_d        = acc_q;
    alu_arg0_d   = alu_arg0_q;
    alu_arg1_d   = alu_arg1_q;
    alu_oper_d   = alu_oper_q;
    rsp_result_d = rsp_result_q;
    rsp_flag_d   = rsp_flag_q;
    if (cmd_hs_c) begin
      alu_arg0_d = i_cmd_chain ? acc_q : i_cmd_arg0;
      alu_arg1_d = i_cmd_arg1;
      alu_oper_d = i_cmd_oper;
    end
    if (capture_c) begin
      rsp_result_d = i_alu_result;
      rsp_flag_d   = alu_flag_t'(i_alu_flag);
      acc_d        = i_alu_result;
    end
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      acc_q        <= '0;
      alu_arg0_q   <= '0;
      alu_arg1_q   <= '0;
      alu_oper_q   <= OPC_W'(OPC_ADD);
      rsp_result_q <= '0;
      rsp_flag_q   <= '0;
    end else begin
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      acc_q        <= acc_d;
      alu_arg0_q   <= alu_arg0_d;
      alu_arg1_q   <= alu_arg1_d;
      alu_oper_q   <= alu_oper_d;
      rsp_result_q <= rsp_result_d;
      rsp_flag_q   <= rsp_flag_d;
    end
  end

  assign o_cmd_ready  = cmd_ready_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_alu_arg0   = alu_arg0_q;
  assign o_alu_arg1   = alu_arg1_q;
  assign o_alu_oper   = alu_oper_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_flag   = rsp_flag_q;

`ifdef ALU_SEQ_STATS_EN
  logic ovf_evt_c;

  // An overflow counts when its result is captured; reset wins over the capture
  assign ovf_evt_c = capture_c && flag_is_ovf(alu_flag_t'(i_alu_flag));

  alu_seq_stats u_stats (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rsp_hs    (rsp_hs_c),
    .i_ovf_evt   (ovf_evt_c),
    .o_op_count  (o_op_count),
    .o_ovf_count (o_ovf_count)
  );
`else
  assign o_op_count  = '0;
  assign o_ovf_count = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with a transaction-level reference model.
module tb_alu_seq;

  localparam int unsigned DW = 10;
  localparam int unsigned OW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_arg0, cmd_arg1;
  logic [OW-1:0] cmd_oper;
  logic          cmd_chain;
  logic [DW-1:0] alu_arg0, alu_arg1;
  logic [OW-1:0] alu_oper;
  logic [DW-1:0] alu_result;
  logic [3:0]    alu_flag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic [3:0]    rsp_flag;
  logic [15:0]   op_count;
  logic [7:0]    ovf_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_seq #(.DATA_W(DW), .OPC_W(OW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_arg0   (cmd_arg0),
    .i_cmd_arg1   (cmd_arg1),
    .i_cmd_oper   (cmd_oper),
    .i_cmd_chain  (cmd_chain),
    .o_alu_arg0   (alu_arg0),
    .o_alu_arg1   (alu_arg1),
    .o_alu_oper   (alu_oper),
    .i_alu_result (alu_result),
    .i_alu_flag   (alu_flag),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_flag   (rsp_flag),
    .o_op_count   (op_count),
    .o_ovf_count  (ovf_count)
  );

  // Reference ALU: signed result plus {NEG,POS,ZERO,OVF}
  function automatic logic [DW+3:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [OW-1:0] op);
    logic signed [DW-1:0] sa, sb, r;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = 1'b0;
    case (op)
      3'd0: begin r = sa + sb; ovf = (sa[DW-1] == sb[DW-1]) && (r[DW-1] != sa[DW-1]); end
      3'd1: begin r = sa - sb; ovf = (sa[DW-1] != sb[DW-1]) && (r[DW-1] != sa[DW-1]); end
      3'd2: r = (sa > sb) ? sa : sb;
      3'd3: r = (sa < sb) ? sa : sb;
      3'd4: r = sa & sb;
      3'd5: r = sa | sb;
      3'd6: r = sa ^ sb;
      default: r = ~(sa ^ sb);
    endcase
    return {r, (r < 0), (r > 0), (r == 0), ovf};
  endfunction

  always_comb {alu_result, alu_flag} = alu_ref(alu_arg0, alu_arg1, alu_oper);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // Transaction model: one command in flight, result available from the 2nd cycle
  bit            m_on = 1'b0;
  bit            m_busy = 1'b0;
  int            m_age = 0;
  logic [DW-1:0] m_acc = '0, m_a0 = '0, m_a1 = '0, m_res = '0;
  logic [OW-1:0] m_op = '0;
  logic [3:0]    m_flag = '0;
  int            m_ops = 0, m_ovf = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on = 1'b1; m_busy = 1'b0; m_age = 0; m_acc = '0;
      m_a0 = '0; m_a1 = '0; m_op = '0; m_res = '0; m_flag = '0;
      m_ops = 0; m_ovf = 0;
    end else if (m_on) begin
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1'b1;
          m_age  = 0;
          m_a0   = cmd_chain ? m_acc : cmd_arg0;
          m_a1   = cmd_arg1;
          m_op   = cmd_oper;
        end
      end else begin
        m_age++;
        if (m_age == 1) begin
          {m_res, m_flag} = alu_ref(m_a0, m_a1, m_op);
          m_acc = m_res;
          if (m_flag[0] && m_ovf < 255) m_ovf++;
        end else if (rsp_ready) begin
          m_busy = 1'b0;
          m_ops  = (m_ops + 1) % 65536;
        end
      end
    end
  end

  // Compare every cycle once the model has seen a reset
  always @(negedge clk) begin
    if (m_on && rst_n) begin
      check("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 1));
      if (m_busy && m_age >= 1) begin
        check("rsp_result", 32'(rsp_result), 32'(m_res));
        check("rsp_flag", 32'(rsp_flag), 32'(m_flag));
      end
      check("alu_arg0", 32'(alu_arg0), 32'(m_a0));
      check("alu_arg1", 32'(alu_arg1), 32'(m_a1));
      check("alu_oper", 32'(alu_oper), 32'(m_op));
`ifdef ALU_SEQ_STATS_EN
      check("op_count", 32'(op_count), 32'(m_ops));
      check("ovf_count", 32'(ovf_count), 32'(m_ovf));
`else
      check("op_count", 32'(op_count), 32'd0);
      check("ovf_count", 32'(ovf_count), 32'd0);
`endif
    end
  end

  // Offer a command until accepted; optionally wait for its response (lat = negedges to valid)
  task automatic send(input logic [DW-1:0] a0, input logic [DW-1:0] a1, input logic [OW-1:0] op,
                      input logic ch, input bit wait_rsp, output int lat);
    int n;
    n   = 0;
    lat = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_arg0 = a0; cmd_arg1 = a1; cmd_oper = op; cmd_chain = ch;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles, expected 1", n);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_arg0  = DW'($urandom);
    cmd_arg1  = DW'($urandom);
    cmd_oper  = OW'($urandom);
    cmd_chain = 1'($urandom);
    if (wait_rsp) begin
      lat = 0;
      while (!rsp_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      if (!rsp_valid) begin
        total++;
        $display("FAIL rsp_timeout: rsp_valid stayed 0 for %0d cycles, expected 1", lat);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish first");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_arg0 = '0; cmd_arg1 = '0;
    cmd_oper = '0; cmd_chain = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_flag", 32'(rsp_flag), 32'd0);
    check("rst_alu_arg0", 32'(alu_arg0), 32'd0);
    check("rst_alu_arg1", 32'(alu_arg1), 32'd0);
    check("rst_alu_oper", 32'(alu_oper), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_ovf_count", 32'(ovf_count), 32'd0);

    // ADD 100,200
    send(10'd100, 10'd200, 3'd0, 1'b0, 1'b1, lat);
    check("add_latency", 32'(lat), 32'd2);
    check("add_result", 32'(rsp_result), 32'd300);
    check("add_flag", 32'(rsp_flag), 32'b0100);

    // ADD 300,300 overflows to -424 (0x258)
    send(10'd300, 10'd300, 3'd0, 1'b0, 1'b1, lat);
    check("ovf_result", 32'(rsp_result), 32'h258);
    check("ovf_flag", 32'(rsp_flag), 32'b1001);
    @(negedge clk);
`ifdef ALU_SEQ_STATS_EN
    check("ovf_count_1", 32'(ovf_count), 32'd1);
`else
    check("ovf_count_off", 32'(ovf_count), 32'd0);
`endif

    // ADD 5,3 then chained SUB 8 right after the response
    send(10'd5, 10'd3, 3'd0, 1'b0, 1'b1, lat);
    check("chain_first", 32'(rsp_result), 32'd8);
    send(10'h3ff, 10'd8, 3'd1, 1'b1, 1'b1, lat);
    check("chain_result", 32'(rsp_result), 32'd0);
    check("chain_flag", 32'(rsp_flag), 32'b0010);

    // Other opcodes
    send(10'h3fb, 10'd3, 3'd3, 1'b0, 1'b1, lat);
    check("min_result", 32'(rsp_result), 32'h3fb);
    check("min_flag", 32'(rsp_flag), 32'b1000);
    send(10'h200, 10'd1, 3'd1, 1'b0, 1'b1, lat);
    check("sub_ovf_result", 32'(rsp_result), 32'h1ff);
    check("sub_ovf_flag", 32'(rsp_flag), 32'b0101);
    send(10'h0, 10'h0, 3'd7, 1'b0, 1'b1, lat);
    check("xnor_result", 32'(rsp_result), 32'h3ff);
    check("xnor_flag", 32'(rsp_flag), 32'b1000);
    send(10'h0f0, 10'h0cc, 3'd4, 1'b0, 1'b1, lat);
    check("and_result", 32'(rsp_result), 32'h0c0);
    send(10'h0f0, 10'h00c, 3'd5, 1'b0, 1'b1, lat);
    check("orr_result", 32'(rsp_result), 32'h0fc);
    send(10'h0f0, 10'h0ff, 3'd6, 1'b0, 1'b1, lat);
    check("xor_result", 32'(rsp_result), 32'h00f);

    // Back-pressure: MAX 7,-2 held in RESP while junk commands are offered
    @(negedge clk);
    rsp_ready = 1'b0;
    send(10'd7, 10'h3fe, 3'd2, 1'b0, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_arg0 = 10'd1; cmd_arg1 = 10'd1; cmd_oper = 3'd0; cmd_chain = 1'b0;
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_result", 32'(rsp_result), 32'd7);
      check("hold_flag", 32'(rsp_flag), 32'b0100);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("release_ready", 32'(cmd_ready), 32'd1);
    check("release_valid", 32'(rsp_valid), 32'd0);

    // Reset during ISSUE discards the operation and clears the accumulator
    send(10'd20, 10'd22, 3'd0, 1'b0, 1'b1, lat);
    send(10'd300, 10'd300, 3'd0, 1'b0, 1'b0, lat);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_issue_ready", 32'(cmd_ready), 32'd1);
    check("rst_issue_valid", 32'(rsp_valid), 32'd0);
    check("rst_issue_ovf", 32'(ovf_count), 32'd0);
    check("rst_issue_ops", 32'(op_count), 32'd0);
    send(10'd99, 10'd7, 3'd0, 1'b1, 1'b1, lat);
    check("rst_issue_acc", 32'(rsp_result), 32'd7);

    // 300 overflowing ADDs from a clean reset
    do_reset();
    for (int i = 0; i < 300; i++) send(10'd300, 10'd300, 3'd0, 1'b0, 1'b1, lat);
    @(negedge clk);
`ifdef ALU_SEQ_STATS_EN
    check("bulk_ovf_count", 32'(ovf_count), 32'd255);
    check("bulk_op_count", 32'(op_count), 32'd300);
`else
    check("bulk_ovf_count", 32'(ovf_count), 32'd0);
    check("bulk_op_count", 32'(op_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
